// File: rtl/sram_arbiter.sv
// Arbitrates the shared SRAM-style channel between instruction fetch and data memory.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise data has fixed priority.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_en,
    input  logic [DATA_WIDTH/8-1:0] inst_write_en,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    input  logic [DATA_WIDTH-1:0]   inst_write_data,
    output logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst_read_data,
    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_write_en,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_write_data,
    output logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   data_read_data,
    output logic                    sram_en,
    input  logic                    sram_ready,
    output logic [DATA_WIDTH/8-1:0] sram_write_en,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_write_data,
    input  logic [DATA_WIDTH-1:0]   sram_read_data,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t                state;
    logic                  grant_data;
    logic                  pick_data;
    logic [DATA_WIDTH-1:0] read_reg;

    // Handshake: a requester holds *_en with stable command until its one-cycle *_ready;
    // requests are only sampled in IDLE, so a held request is never lost.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_data;
    assign pick_data = data_en && (!inst_en || !last_grant_data);
`else
    assign pick_data = data_en;
`endif

    assign inst_read_data = read_reg;
    assign data_read_data = read_reg;
    assign dbg_state      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant_data      <= 1'b0;
            sram_en         <= 1'b0;
            inst_ready      <= 1'b0;
            data_ready      <= 1'b0;
            read_reg        <= '0;
            sram_write_en   <= '0;
            sram_addr       <= '0;
            sram_write_data <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_grant_data <= 1'b0;
`endif
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_en || data_en) begin
                        grant_data      <= pick_data;
                        sram_write_en   <= pick_data ? data_write_en   : inst_write_en;
                        sram_addr       <= pick_data ? data_addr       : inst_addr;
                        sram_write_data <= pick_data ? data_write_data : inst_write_data;
                        sram_en         <= 1'b1;
                        state           <= ISSUE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        last_grant_data <= pick_data;
`endif
                    end
                end
                ISSUE: begin
                    // The command is accepted on the first edge with sram_ready high.
                    if (sram_ready) begin
                        sram_en <= 1'b0;
                        state   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!sram_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sram_ready) begin
                        read_reg   <= sram_read_data;
                        inst_ready <= !grant_data;
                        data_ready <= grant_data;
                        state      <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level timing model, read-data scoreboard,
// behavioural downstream with configurable stall/busy, and directed scenarios.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_en = 1'b0, data_en = 1'b0;
    logic [3:0]  inst_write_en = '0, data_write_en = '0;
    logic [31:0] inst_addr = '0, data_addr = '0;
    logic [31:0] inst_write_data = '0, data_write_data = '0;
    logic        inst_ready, data_ready;
    logic [31:0] inst_read_data, data_read_data;
    logic        sram_en;
    logic        sram_ready = 1'b1;
    logic [3:0]  sram_write_en;
    logic [31:0] sram_addr, sram_write_data;
    logic [31:0] sram_read_data = '0;
    logic [2:0]  dbg_state;

    sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_write_en(inst_write_en), .inst_addr(inst_addr),
        .inst_write_data(inst_write_data), .inst_ready(inst_ready), .inst_read_data(inst_read_data),
        .data_en(data_en), .data_write_en(data_write_en), .data_addr(data_addr),
        .data_write_data(data_write_data), .data_ready(data_ready), .data_read_data(data_read_data),
        .sram_en(sram_en), .sram_ready(sram_ready), .sram_write_en(sram_write_en),
        .sram_addr(sram_addr), .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // requester drivers
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;
    req_t inst_q[$];
    req_t data_q[$];

    initial begin
        forever begin
            @(posedge clk); #1;
            if (inst_en && inst_ready && inst_q.size() > 0) void'(inst_q.pop_front());
            if (inst_q.size() > 0) begin
                inst_en = 1'b1; inst_write_en = inst_q[0].we;
                inst_addr = inst_q[0].addr; inst_write_data = inst_q[0].wd;
            end else inst_en = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (data_en && data_ready && data_q.size() > 0) void'(data_q.pop_front());
            if (data_q.size() > 0) begin
                data_en = 1'b1; data_write_en = data_q[0].we;
                data_addr = data_q[0].addr; data_write_data = data_q[0].wd;
            end else data_en = 1'b0;
        end
    end

    // downstream behaviour and its returned data
    int          stall_cfg = 0;
    int          busy_cfg = 1;
    logic        ret_fixed_en = 1'b0;
    logic [31:0] ret_fixed = '0;
    int          ds_busy = 0, ds_wait = 0;

    function automatic logic [31:0] ret_fn(input logic [31:0] a, input logic [3:0] we);
        if (ret_fixed_en) return ret_fixed;
        return {a[15:0], a[31:16]} ^ {28'h0, we};
    endfunction

    // transaction-level model state
    logic        m_active = 1'b0, m_gdata = 1'b0, m_last_data = 1'b0;
    int          t_issue = 0, t_acc = 0, t_ready = 0;
    logic [31:0] m_rdata = '0, m_ret = '0;
    logic [3:0]  m_we = '0, p_we = '0;
    logic [31:0] m_addr = '0, m_wd = '0, p_addr = '0, p_wd = '0;
    logic [31:0] exp_q[$];
    int          grant_log[$];
    int          act_log[$];

    // observation counters for the directed literal checks
    int          en_cnt = 0, en_first = -1, acc_cnt = 0, i_cnt = 0, d_cnt = 0, i_cyc = -1;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;

    task automatic clear_mon();
        en_cnt = 0; en_first = -1; acc_cnt = 0; i_cnt = 0; d_cnt = 0; i_cyc = -1;
        d_we = '0; d_addr = '0;
    endtask

    // compare process: model prediction vs DUT every cycle, then advance model and downstream
    always @(negedge clk) begin
        logic exp_en, exp_ir, exp_dr, g;
        if (rst) begin
            chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
            chk("rst_ready", {30'b0, inst_ready, data_ready}, 32'd0);
            chk("rst_read_data", inst_read_data, 32'd0);
            m_active = 1'b0; m_last_data = 1'b0; m_rdata = '0;
            m_we = '0; m_addr = '0; m_wd = '0;
            exp_q.delete();
            sram_ready = 1'b1; sram_read_data = '0; ds_busy = 0; ds_wait = 0;
        end else begin
            if (m_active && cyc == t_issue) begin m_we = p_we; m_addr = p_addr; m_wd = p_wd; end
            if (m_active && cyc == t_ready) m_rdata = m_ret;
            exp_en = m_active && cyc >= t_issue && cyc <= t_acc;
            exp_ir = m_active && cyc == t_ready && !m_gdata;
            exp_dr = m_active && cyc == t_ready && m_gdata;
            chk("sram_en", {31'b0, sram_en}, {31'b0, exp_en});
            chk("inst_ready", {31'b0, inst_ready}, {31'b0, exp_ir});
            chk("data_ready", {31'b0, data_ready}, {31'b0, exp_dr});
            chk("inst_read_data", inst_read_data, m_rdata);
            chk("data_read_data", data_read_data, m_rdata);
            chk("sram_addr", sram_addr, m_addr);
            chk("sram_write_en", {28'b0, sram_write_en}, {28'b0, m_we});
            chk("sram_write_data", sram_write_data, m_wd);

            if (inst_ready || data_ready) begin
                if (exp_q.size() == 0) fail_now("sb_unexpected_ready");
                else chk("sb_read_data", inst_read_data, exp_q.pop_front());
                act_log.push_back(data_ready ? 1 : 0);
            end
            if (inst_ready) begin i_cnt++; i_cyc = cyc; end
            if (data_ready) begin d_cnt++; d_we = sram_write_en; d_addr = sram_addr; end
            if (sram_en) begin en_cnt++; if (en_first < 0) en_first = cyc; end

            if (m_active && cyc == t_ready) m_active = 1'b0;
            else if (!m_active && (inst_en || data_en)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                g = data_en && (!inst_en || !m_last_data);
`else
                g = data_en;
`endif
                m_last_data = g;
                m_active = 1'b1; m_gdata = g;
                p_we   = g ? data_write_en : inst_write_en;
                p_addr = g ? data_addr : inst_addr;
                p_wd   = g ? data_write_data : inst_write_data;
                t_issue = cyc + 1;
                t_acc   = t_issue + stall_cfg;
                t_ready = t_acc + 2 + busy_cfg;
                m_ret = ret_fn(p_addr, p_we);
                exp_q.push_back(m_ret);
                grant_log.push_back(g ? 1 : 0);
            end

            if (ds_busy > 0) begin
                sram_ready = 1'b0; sram_read_data = 32'hDEAD_BEEF; ds_busy--;
            end else if (sram_en && ds_wait < stall_cfg) begin
                sram_ready = 1'b0; sram_read_data = 32'hDEAD_BEEF; ds_wait++;
            end else begin
                sram_ready = 1'b1; sram_read_data = ret_fn(sram_addr, sram_write_en);
            end
            if (sram_en && sram_ready) begin ds_busy = busy_cfg; ds_wait = 0; acc_cnt++; end
        end
    end

    task automatic wait_done(input string name, input int budget);
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk); #1;
            if (inst_q.size() == 0 && data_q.size() == 0 && !m_active) done = 1;
        end
        if (!done) fail_now(name);
    endtask

    task automatic align();
        @(posedge clk); #3;
    endtask

    int exp_order[4];

    initial begin
        bit found;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sram_en", {31'b0, sram_en}, 32'd0);
        chk("reset_inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("reset_data_ready", {31'b0, data_ready}, 32'd0);
        chk("reset_read_data", data_read_data, 32'd0);
        chk("reset_sram_addr", sram_addr, 32'd0);
        chk("reset_state", {29'b0, dbg_state}, 32'd0);
        rst = 1'b0;

        // contention: both queues full, four transactions each
        align();
        busy_cfg = 1; stall_cfg = 0; ret_fixed_en = 1'b0;
        act_log.delete(); grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            inst_q.push_back('{4'h0, 32'h0000_0100 + 32'(i * 4), 32'h0});
            data_q.push_back('{(i % 2 == 1) ? 4'hF : 4'h0, 32'h8000_0000 + 32'(i * 8), 32'hA0 + 32'(i)});
        end
        wait_done("contention_timeout", 200);
        chk("contention_count", act_log.size(), 32'd8);
        if (act_log.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("grant_order_dut", act_log[i], exp_order[i]);
                chk("grant_order_model", grant_log[i], exp_order[i]);
            end

        // instruction read alone, downstream busy 2 cycles
        align();
        clear_mon();
        busy_cfg = 2; ret_fixed_en = 1'b1; ret_fixed = 32'h3C1D_0000;
        inst_q.push_back('{4'h0, 32'h1FC0_0000, 32'h0});
        wait_done("inst_read_timeout", 40);
        chk("inst_read_latency", i_cyc - en_first, 32'd4);
        chk("inst_read_pulses", i_cnt, 32'd1);
        chk("inst_read_no_data_ready", d_cnt, 32'd0);
        chk("inst_read_en_cycles", en_cnt, 32'd1);
        chk("inst_read_value", inst_read_data, 32'h3C1D_0000);

        // data write alone
        align();
        clear_mon();
        busy_cfg = 1; ret_fixed_en = 1'b0;
        data_q.push_back('{4'b1100, 32'h8000_1002, 32'h1234_0000});
        wait_done("data_write_timeout", 40);
        chk("data_write_strobe", {28'b0, d_we}, 32'h0000_000C);
        chk("data_write_addr", d_addr, 32'h8000_1002);
        chk("data_write_en_cycles", en_cnt, 32'd1);
        chk("data_write_pulses", d_cnt, 32'd1);
        chk("data_write_no_inst_ready", i_cnt, 32'd0);
        chk("data_write_capture", data_read_data, 32'h1002_800C);

        // downstream not ready at issue for 3 cycles
        align();
        clear_mon();
        stall_cfg = 3; busy_cfg = 1; ret_fixed_en = 1'b1; ret_fixed = 32'h0BAD_F00D;
        inst_q.push_back('{4'h0, 32'h0000_4000, 32'h0});
        wait_done("stall_timeout", 40);
        chk("stall_en_cycles", en_cnt, 32'd4);
        chk("stall_accepts", acc_cnt, 32'd1);
        chk("stall_latency", i_cyc - en_first, 32'd6);
        stall_cfg = 0;

        // asynchronous reset while waiting for completion
        align();
        clear_mon();
        busy_cfg = 4; ret_fixed = 32'h1111_2222;
        inst_q.push_back('{4'h0, 32'h0000_2000, 32'h0});
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (dbg_state == 3'd3) found = 1;
        end
        if (!found) fail_now("reach_wait_done");
        #1;
        rst = 1'b1;
        inst_q.delete();
        #1;
        chk("async_rst_sram_en", {31'b0, sram_en}, 32'd0);
        chk("async_rst_ready", {30'b0, inst_ready, data_ready}, 32'd0);
        chk("async_rst_read_data", inst_read_data, 32'd0);
        chk("async_rst_state", {29'b0, dbg_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("async_rst_no_pulse", i_cnt + d_cnt, 32'd0);

        // normal operation after reset
        align();
        clear_mon();
        busy_cfg = 1; ret_fixed = 32'hCAFE_F00D;
        inst_q.push_back('{4'h0, 32'h1FC0_0010, 32'h0});
        wait_done("post_reset_timeout", 40);
        chk("post_reset_latency", i_cyc - en_first, 32'd3);
        chk("post_reset_pulses", i_cnt, 32'd1);
        chk("post_reset_value", inst_read_data, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the single SRAM-style channel in front of the AXI adapter between the instruction-fetch and data-memory requesters.
- Grants one requester at a time and latches its command.
- Drives the downstream channel with a one-cycle enable, waits for completion, then returns a one-cycle ready pulse and the read data to the granted requester.
- Sits between the core's fetch/memory stages and the AXI adapter.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 32, data width of all ports; `write_en` width is `DATA_WIDTH/8`
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `inst_en`, `data_en`  in  1  request valid; held until the matching `*_ready` pulse
- `inst_write_en`, `data_write_en`  in  4  byte strobes; 0 = read, nonzero = write
- `inst_addr`, `data_addr`  in  32  request address
- `inst_write_data`, `data_write_data`  in  32  store data
- `inst_ready`, `data_ready`  out  1  one-cycle completion pulse
- `inst_read_data`, `data_read_data`  out  32  read result; valid in the `*_ready` cycle
- `sram_en`  out  1  downstream command strobe
- `sram_ready`  in  1  downstream idle/complete level
- `sram_write_en`  out  4  downstream byte strobes
- `sram_addr`  out  32  downstream address
- `sram_write_data`  out  32  downstream store data
- `sram_read_data`  in  32  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_DONE, RESP.
- IDLE:
  - If any `*_en` is high, choose the grant and latch that requester's `write_en`, `addr` and `write_data` into command registers.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `sram_en`=1.
  - If `sram_ready`=1, go to WAIT_LOW. Otherwise hold `sram_en` and stay.
- WAIT_LOW: stay until `sram_ready`=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay until `sram_ready`=1.
  - Then capture `sram_read_data` into the shared read register (writes capture too) and go to RESP.
- RESP: pulse `ready` for the granted requester only, then go to IDLE.
- `sram_write_en`, `sram_addr` and `sram_write_data` always come from the command registers. They are stable from ISSUE through WAIT_DONE.
- Both `*_read_data` outputs show the shared read register; it holds until the next capture.
- Arbitration with both requesting in IDLE: see Configuration. A single requester is always granted.
- Requester rule: deassert `en` (or present a new request) in the cycle after `ready`. The arbiter never samples requests outside IDLE.

## Timing
- Reset values:
  - FSM = IDLE.
  - `sram_en`=0, `inst_ready`=`data_ready`=0.
  - Read register = 0.
  - Command registers = 0.
  - last-grant = inst.
- `en` sampled high in IDLE at cycle 0:
  - `sram_en` is high in cycle 1.
  - If the downstream is busy for B≥1 cycles after accepting, `ready` pulses in cycle 3+B.
- `sram_en` is never high for more than one cycle while `sram_ready`=1.
- `*_ready` is exactly one cycle wide and never asserted for both requesters in the same cycle.
- Reset mid-operation:
  - Immediate return to reset values.
  - Any in-flight downstream transaction is abandoned; the downstream shares `rst`.
- A request arriving while not in IDLE waits; no request is lost if held per protocol.
- `sram_ready`=0 at ISSUE entry: `sram_en` stays high until `sram_ready`=1.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant the requester not granted last.
  - last-grant updates at every grant.
  - Reset last-grant = inst, so the first contention goes to data.
- `SRAM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, data always wins over inst; the last-grant register is not built.

## Test plan
- Inst read alone, addr 0x1FC00000; downstream busy 2 cycles returning 0x3C1D0000 → `sram_en` in cycle 1, `inst_ready` pulse in cycle 5, `inst_read_data`=0x3C1D0000, `data_ready` stays 0.
- Data write alone, strobe 4'b1100, addr 0x80001002, data 0x12340000 → `sram_write_en`=4'b1100 and `sram_addr`=0x80001002 held stable until `data_ready`; exactly one `sram_en` cycle.
- Both requesting continuously for 4 transactions:
  - with the macro, grant order data, inst, data, inst;
  - without it, data four times while inst starves.
- `sram_ready` held low for 3 cycles at ISSUE → `sram_en` high all 3 cycles, single transaction issued once ready rises.
- `rst` asserted in WAIT_DONE → same-cycle (asynchronous) `sram_en`=0, no `*_ready` pulse, read data 0; after release, a new inst request completes normally.
